// File: rtl/ode_pkg.sv
// ode_pkg: shared owner encodings, arbiter state type and default RAM widths.
package ode_pkg;
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IO = 2'b01;
  localparam logic [1:0] OWN_SLV = 2'b10;
  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 64;
  typedef enum logic [1:0] {ST_IDLE, ST_OWN_IO, ST_OWN_SLV} arb_state_t;
endpackage

// File: rtl/ram_port_mux.sv
// ram_port_mux: selects the owning requester's write/read buses onto the RAM, zero when idle.
module ram_port_mux import ode_pkg::*; #(
  parameter int AW = DEF_ADDR_W,
  parameter int DW = DEF_DATA_W
) (
  input  logic [1:0]    sel,
  input  logic          io_wr,
  input  logic [AW-1:0] io_wa,
  input  logic [AW-1:0] io_ra1,
  input  logic [AW-1:0] io_ra2,
  input  logic [DW-1:0] io_wd,
  input  logic          slv_wr,
  input  logic [AW-1:0] slv_wa,
  input  logic [AW-1:0] slv_ra1,
  input  logic [AW-1:0] slv_ra2,
  input  logic [DW-1:0] slv_wd,
  output logic          wr,
  output logic [AW-1:0] wa,
  output logic [AW-1:0] ra1,
  output logic [AW-1:0] ra2,
  output logic [DW-1:0] wd
);
  logic io, slv;
  assign io = sel == OWN_IO;
  assign slv = sel == OWN_SLV;
  assign wr = io ? io_wr : slv ? slv_wr : 1'b0;
  assign wa = io ? io_wa : slv ? slv_wa : '0;
  assign ra1 = io ? io_ra1 : slv ? slv_ra1 : '0;
  assign ra2 = io ? io_ra2 : slv ? slv_ra2 : '0;
  assign wd = io ? io_wd : slv ? slv_wd : '0;
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: burst-capped grant FSM sharing one RAM between IO and solver, with read-valid tagging.
module ram_port_arbiter import ode_pkg::*; #(
  parameter int RAM_ADDRESS_WIDTH = DEF_ADDR_W,
  parameter int DATA_WIDTH = DEF_DATA_W,
  parameter int MAX_BURST = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         Load_Process,
  input  logic                         IO_Req,
  input  logic                         IO_Last,
  output logic                         IO_Gnt,
  input  logic                         IO_WR_Enable,
  input  logic                         IO_RD_Enable,
  input  logic [RAM_ADDRESS_WIDTH-1:0] IO_WR_Address,
  input  logic [RAM_ADDRESS_WIDTH-1:0] IO_RD1_Address,
  input  logic [RAM_ADDRESS_WIDTH-1:0] IO_RD2_Address,
  input  logic [DATA_WIDTH-1:0]        IO_WR_Data,
  output logic                         IO_RD_Valid,
  input  logic                         SLV_Req,
  input  logic                         SLV_Last,
  output logic                         SLV_Gnt,
  input  logic                         SLV_WR_Enable,
  input  logic                         SLV_RD_Enable,
  input  logic [RAM_ADDRESS_WIDTH-1:0] SLV_WR_Address,
  input  logic [RAM_ADDRESS_WIDTH-1:0] SLV_RD1_Address,
  input  logic [RAM_ADDRESS_WIDTH-1:0] SLV_RD2_Address,
  input  logic [DATA_WIDTH-1:0]        SLV_WR_Data,
  output logic                         SLV_RD_Valid,
  output logic                         RAM_WR_Enable,
  output logic [RAM_ADDRESS_WIDTH-1:0] RAM_WR_Address,
  output logic [RAM_ADDRESS_WIDTH-1:0] RAM_RD1_Address,
  output logic [RAM_ADDRESS_WIDTH-1:0] RAM_RD2_Address,
  output logic [DATA_WIDTH-1:0]        RAM_WR_Data,
  output logic [1:0]                   Owner
);
  localparam int CW = $clog2(MAX_BURST);
  localparam logic [CW-1:0] CAP = CW'(MAX_BURST - 1);
  arb_state_t state, next;
  logic [CW-1:0] cnt;
  logic io_end, slv_end, cap;
  assign io_end = IO_Last || !IO_Req;
  assign slv_end = SLV_Last || !SLV_Req;
  assign cap = cnt == CAP;
  // A saturated counter hands off as soon as the other side asks.
  always_comb
    next = state == ST_IDLE ? (IO_Req && (Load_Process || !SLV_Req) ? ST_OWN_IO : SLV_Req ? ST_OWN_SLV : ST_IDLE)
         : state == ST_OWN_IO ? ((io_end || cap) && SLV_Req ? ST_OWN_SLV : io_end ? ST_IDLE : ST_OWN_IO)
         : ((slv_end || cap) && IO_Req ? ST_OWN_IO : slv_end ? ST_IDLE : ST_OWN_SLV);
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      cnt <= '0;
      IO_Gnt <= 1'b0;
      SLV_Gnt <= 1'b0;
      Owner <= OWN_NONE;
      IO_RD_Valid <= 1'b0;
      SLV_RD_Valid <= 1'b0;
    end else begin
      state <= next;
      cnt <= next != state ? '0 : (state != ST_IDLE && !cap) ? cnt + 1'b1 : cnt;
      IO_Gnt <= next == ST_OWN_IO;
      SLV_Gnt <= next == ST_OWN_SLV;
      Owner <= next == ST_OWN_IO ? OWN_IO : next == ST_OWN_SLV ? OWN_SLV : OWN_NONE;
      IO_RD_Valid <= IO_Gnt && IO_RD_Enable;
      SLV_RD_Valid <= SLV_Gnt && SLV_RD_Enable;
    end
  end
  ram_port_mux #(.AW(RAM_ADDRESS_WIDTH), .DW(DATA_WIDTH)) u_mux (
    .sel(Owner),
    .io_wr(IO_WR_Enable && IO_Gnt),
    .io_wa(IO_WR_Address),
    .io_ra1(IO_RD1_Address),
    .io_ra2(IO_RD2_Address),
    .io_wd(IO_WR_Data),
    .slv_wr(SLV_WR_Enable && SLV_Gnt),
    .slv_wa(SLV_WR_Address),
    .slv_ra1(SLV_RD1_Address),
    .slv_ra2(SLV_RD2_Address),
    .slv_wd(SLV_WR_Data),
    .wr(RAM_WR_Enable),
    .wa(RAM_WR_Address),
    .ra1(RAM_RD1_Address),
    .ra2(RAM_RD2_Address),
    .wd(RAM_WR_Data)
  );
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: table-driven cycle vectors plus handoff, forced-handoff, reset and saturation sequences.
module tb_ram_port_arbiter;
  localparam int AW = 13;
  localparam int DW = 64;
  logic CLK = 1'b0;
  logic RST, Load_Process;
  logic IO_Req, IO_Last, IO_Gnt, IO_WR_Enable, IO_RD_Enable, IO_RD_Valid;
  logic SLV_Req, SLV_Last, SLV_Gnt, SLV_WR_Enable, SLV_RD_Enable, SLV_RD_Valid;
  logic [AW-1:0] IO_WR_Address, IO_RD1_Address, IO_RD2_Address;
  logic [AW-1:0] SLV_WR_Address, SLV_RD1_Address, SLV_RD2_Address;
  logic [DW-1:0] IO_WR_Data, SLV_WR_Data, RAM_WR_Data;
  logic RAM_WR_Enable;
  logic [AW-1:0] RAM_WR_Address, RAM_RD1_Address, RAM_RD2_Address;
  logic [1:0] Owner;
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ram_port_arbiter #(.RAM_ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(16)) dut (
    .CLK(CLK), .RST(RST), .Load_Process(Load_Process),
    .IO_Req(IO_Req), .IO_Last(IO_Last), .IO_Gnt(IO_Gnt),
    .IO_WR_Enable(IO_WR_Enable), .IO_RD_Enable(IO_RD_Enable),
    .IO_WR_Address(IO_WR_Address), .IO_RD1_Address(IO_RD1_Address), .IO_RD2_Address(IO_RD2_Address),
    .IO_WR_Data(IO_WR_Data), .IO_RD_Valid(IO_RD_Valid),
    .SLV_Req(SLV_Req), .SLV_Last(SLV_Last), .SLV_Gnt(SLV_Gnt),
    .SLV_WR_Enable(SLV_WR_Enable), .SLV_RD_Enable(SLV_RD_Enable),
    .SLV_WR_Address(SLV_WR_Address), .SLV_RD1_Address(SLV_RD1_Address), .SLV_RD2_Address(SLV_RD2_Address),
    .SLV_WR_Data(SLV_WR_Data), .SLV_RD_Valid(SLV_RD_Valid),
    .RAM_WR_Enable(RAM_WR_Enable), .RAM_WR_Address(RAM_WR_Address),
    .RAM_RD1_Address(RAM_RD1_Address), .RAM_RD2_Address(RAM_RD2_Address),
    .RAM_WR_Data(RAM_WR_Data), .Owner(Owner)
  );

  // in:  {rst, load, io_req, io_last, io_wr, io_rd, slv_req, slv_last, slv_wr, slv_rd}
  // exp: {io_gnt, slv_gnt, owner[1:0], ram_wr, io_rdv, slv_rdv}
  typedef struct {
    logic [9:0] in;
    logic [6:0] exp;
    string name;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic step(input logic [9:0] in, input logic [6:0] ex, input string nm);
    logic [102:0] bus;
    @(negedge CLK);
    {RST, Load_Process, IO_Req, IO_Last, IO_WR_Enable, IO_RD_Enable,
     SLV_Req, SLV_Last, SLV_WR_Enable, SLV_RD_Enable} = in;
    #1;
    bus = ex[4:3] == 2'b01 ? {IO_WR_Address, IO_RD1_Address, IO_RD2_Address, IO_WR_Data}
        : ex[4:3] == 2'b10 ? {SLV_WR_Address, SLV_RD1_Address, SLV_RD2_Address, SLV_WR_Data} : '0;
    chk({nm, " grants"}, 128'({IO_Gnt, SLV_Gnt}), 128'(ex[6:5]));
    chk({nm, " owner"}, 128'(Owner), 128'(ex[4:3]));
    chk({nm, " ram_wr"}, 128'(RAM_WR_Enable), 128'(ex[2]));
    chk({nm, " ram_bus"}, 128'({RAM_WR_Address, RAM_RD1_Address, RAM_RD2_Address, RAM_WR_Data}), 128'(bus));
    chk({nm, " rd_valid"}, 128'({IO_RD_Valid, SLV_RD_Valid}), 128'(ex[1:0]));
  endtask

  vec_t v[14];

  initial begin
    RST = 1'b1;
    {Load_Process, IO_Req, IO_Last, IO_WR_Enable, IO_RD_Enable} = '0;
    {SLV_Req, SLV_Last, SLV_WR_Enable, SLV_RD_Enable} = '0;
    IO_WR_Address = 13'd5;
    IO_RD1_Address = 13'd7;
    IO_RD2_Address = 13'd8;
    IO_WR_Data = 64'h0123456789ABCDEF;
    SLV_WR_Address = 13'd100;
    SLV_RD1_Address = 13'd101;
    SLV_RD2_Address = 13'd102;
    SLV_WR_Data = 64'hFEDCBA9876543210;
    v[0]  = '{10'b10_0000_0000, 7'b00_00_0_00, "reset"};
    v[1]  = '{10'b00_1010_0010, 7'b00_00_0_00, "io_req_idle"};
    v[2]  = '{10'b00_1010_0010, 7'b10_01_1_00, "io_write"};
    v[3]  = '{10'b00_1101_0000, 7'b10_01_0_00, "io_read_last"};
    v[4]  = '{10'b00_0000_0000, 7'b00_00_0_10, "io_rdv"};
    v[5]  = '{10'b01_1000_1000, 7'b00_00_0_00, "tie_load1"};
    v[6]  = '{10'b01_1100_1000, 7'b10_01_0_00, "tie_io_won"};
    v[7]  = '{10'b00_0000_1111, 7'b01_10_1_00, "slv_wr_rd_last"};
    v[8]  = '{10'b00_1000_1000, 7'b00_00_0_01, "tie_load0"};
    v[9]  = '{10'b00_1010_1000, 7'b01_10_0_00, "tie_slv_won"};
    v[10] = '{10'b00_1001_0000, 7'b01_10_0_00, "slv_drop"};
    v[11] = '{10'b00_1000_0000, 7'b10_01_0_00, "io_after_drop"};
    v[12] = '{10'b00_0000_0000, 7'b10_01_0_00, "io_drop"};
    v[13] = '{10'b00_0000_0000, 7'b00_00_0_00, "idle"};
    repeat (2) @(posedge CLK);
    for (int i = 0; i < 14; i++) step(v[i].in, v[i].exp, v[i].name);
    // IO burst ends with Last on its 4th granted cycle; solver takes over with no bubble
    step(10'b00_1000_0000, 7'b00_00_0_00, "ho_req");
    for (int i = 1; i <= 3; i++) step(10'b00_1000_1000, 7'b10_01_0_00, "ho_io");
    step(10'b00_1100_1000, 7'b10_01_0_00, "ho_last");
    step(10'b00_0000_1100, 7'b01_10_0_00, "ho_slv");
    step(10'b00_0000_0000, 7'b00_00_0_00, "ho_idle");
    // IO never asserts Last: exactly 16 granted cycles, read on the last one
    step(10'b01_1000_1000, 7'b00_00_0_00, "forced_req");
    for (int i = 1; i <= 16; i++)
      step(i == 16 ? 10'b01_1001_1000 : 10'b01_1000_1000, 7'b10_01_0_00, "forced_io");
    step(10'b01_1000_1000, 7'b01_10_0_10, "forced_slv");
    // reset while solver owns the RAM and issues a read
    step(10'b11_1000_1001, 7'b01_10_0_00, "rst_assert");
    step(10'b00_0000_0010, 7'b00_00_0_00, "after_rst");
    // solver alone saturates its counter, then yields at once when IO asks
    step(10'b00_0000_1000, 7'b00_00_0_00, "sat_idle");
    for (int i = 1; i <= 20; i++) step(10'b00_0000_1000, 7'b01_10_0_00, "sat_hold");
    step(10'b00_1000_1000, 7'b01_10_0_00, "sat_req");
    step(10'b00_1000_1000, 7'b10_01_0_00, "sat_handoff");
    step(10'b00_0000_0000, 7'b10_01_0_00, "sat_io_drop");
    step(10'b00_0000_0000, 7'b00_00_0_00, "sat_idle_end");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
